// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store stage: funct3 access sizes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the addressed byte/halfword lane out of a
// read word and sign- or zero-extends it to 32 bits.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_offset)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    // Halfword accesses are known aligned here, so only offset[1] matters.
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_result = i_rdata;
    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'd0, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access stage: byte/half/word loads and stores over a req/ready memory
// handshake, stalling upstream while an access is outstanding.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  err_o,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BE_WIDTH-1:0]   mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_rdata;
  logic [BE_WIDTH-1:0]   r_be;
  logic                  r_we;
  logic [2:0]            r_funct3;

  logic                  w_op, w_illegal, w_misaligned, w_err, w_accept;
  logic [BE_WIDTH-1:0]   w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_load;

  always_comb begin
    w_op      = valid_i & (MemRead | MemWrite);
    w_illegal = 1'b0;
    if (MemRead && MemWrite)
      w_illegal = 1'b1;
    else if (MemRead)
      w_illegal = funct3 inside {3'b011, 3'b110, 3'b111};
    else if (MemWrite)
      w_illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    w_misaligned = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                   ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
    w_err    = (r_state == IDLE) && w_op && (w_illegal || w_misaligned);
    w_accept = (r_state == IDLE) && w_op && !(w_illegal || w_misaligned);
  end

  // Store lane steering: replicate data so any enabled lane sees the right bytes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {ALUResult[1], 1'b0};
        w_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = REQ;
      REQ:     if (mem_ready) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  load_extend u_load_extend (
    .i_rdata  (mem_rdata),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_result (w_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_be     <= '0;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= ALUResult;
        r_wdata  <= w_wdata;
        r_be     <= w_be;
        r_we     <= MemWrite;
        r_funct3 <= funct3;
      end
      if ((r_state == REQ) && mem_ready && !r_we)
        r_rdata <= w_load;
    end
  end

  assign err_o     = w_err;
  assign stall_o   = w_accept || (r_state == REQ);
  assign done_o    = (r_state == RESP);
  assign ReadData  = r_rdata;
  assign mem_req   = (r_state == REQ);
  assign mem_we    = (r_state == REQ) && r_we;
  assign mem_addr  = {r_addr[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata = r_wdata;
  assign mem_be    = (r_state == REQ) ? r_be : '0;

endmodule
